// File: rtl/matrix_row_scanner.sv
// matrix_row_scanner
// Row-scan sequencer for a 5x7 LED matrix that shows 2-of-5 coded digits.
// A code word arrives on a one-cycle load strobe and is accepted only if it
// has exactly two ones. An accepted word waits in a shadow register and is
// moved to the display outputs only at a frame boundary, or on the start of
// a scan, so a frame never shows two different codes. Rows 1..7 are driven
// on A/B/C, and each row is held for PRESCALE clock cycles. A/B/C = 000
// blanks the downstream column decoder.
//
// Ports:
//   clk        system clock, rising edge
//   rst        synchronous active-high reset
//   en         scan enable; 0 blanks the display
//   code_in    candidate code word (bit 4 = E1 ... bit 0 = E5)
//   load       one-cycle strobe that samples code_in
//   E1..E5     displayed code word, registered
//   A, B, C    row index, A = MSB; 001..111 = rows 1..7, 000 = blank
//   frame_done one-cycle pulse on the last cycle of row 7
//   code_err   sticky flag, set by an invalid load, cleared by a valid load
//   pending    a valid code is waiting in the shadow register
module matrix_row_scanner #(
    parameter int unsigned PRESCALE = 4
) (
    input  logic       clk,
    input  logic       rst,
    input  logic       en,
    input  logic [4:0] code_in,
    input  logic       load,
    output logic       E1,
    output logic       E2,
    output logic       E3,
    output logic       E4,
    output logic       E5,
    output logic       A,
    output logic       B,
    output logic       C,
    output logic       frame_done,
    output logic       code_err,
    output logic       pending
);

    localparam int unsigned CW = (PRESCALE > 1) ? $clog2(PRESCALE) : 1;
    localparam logic [CW-1:0] CNT_LAST = CW'(PRESCALE - 1);

    typedef enum logic {
        IDLE,
        SCAN
    } stateT;

    stateT          state, stateNext;
    logic [2:0]     row, rowNext;
    logic [CW-1:0]  cnt, cntNext;
    logic [4:0]     disp, dispNext;
    logic [4:0]     shadow, shadowNext;
    logic           pendingReg, pendingNext;
    logic           errReg, errNext;
    logic           frameDoneReg, frameDoneNext;
    logic           loadValid;

    always_ff @(posedge clk) begin
        if (rst) begin
            state        <= IDLE;
            row          <= '0;
            cnt          <= '0;
            disp         <= '0;
            shadow       <= '0;
            pendingReg   <= 1'b0;
            errReg       <= 1'b0;
            frameDoneReg <= 1'b0;
        end else begin
            state        <= stateNext;
            row          <= rowNext;
            cnt          <= cntNext;
            disp         <= dispNext;
            shadow       <= shadowNext;
            pendingReg   <= pendingNext;
            errReg       <= errNext;
            frameDoneReg <= frameDoneNext;
        end
    end

    always_comb begin
        stateNext   = state;
        rowNext     = row;
        cntNext     = cnt;
        dispNext    = disp;
        shadowNext  = shadow;
        pendingNext = pendingReg;
        errNext     = errReg;

        loadValid = load && ($countones(code_in) == 2);

        if (load) begin
            if (loadValid) begin
                errNext     = 1'b0;
                shadowNext  = code_in;
                pendingNext = 1'b1;
            end else begin
                errNext = 1'b1;
            end
        end

        case (state)
            IDLE: begin
                // Leaving IDLE uses only the registered pending flag. A load
                // seen on this same edge stays in the shadow register.
                if (en && (pendingReg || disp != '0)) begin
                    stateNext = SCAN;
                    rowNext   = 3'd1;
                    cntNext   = '0;
                    if (pendingReg) begin
                        dispNext = shadow;
                        if (!loadValid) pendingNext = 1'b0;
                    end
                end
            end
            SCAN: begin
                if (!en) begin
                    stateNext = IDLE;
                    rowNext   = '0;
                    cntNext   = '0;
                end else if (cnt == CNT_LAST) begin
                    cntNext = '0;
                    if (row == 3'd7) begin
                        rowNext = 3'd1;
                        // At the frame boundary a load on the same edge goes
                        // straight to the display, so it is never left pending.
                        if (loadValid) begin
                            dispNext    = code_in;
                            pendingNext = 1'b0;
                        end else if (pendingReg) begin
                            dispNext    = shadow;
                            pendingNext = 1'b0;
                        end
                    end else begin
                        rowNext = row + 3'd1;
                    end
                end else begin
                    cntNext = cnt + 1'b1;
                end
            end
            default: begin
                stateNext = IDLE;
                rowNext   = '0;
                cntNext   = '0;
            end
        endcase

        // frame_done is registered. It is set on the edge that enters the
        // last cycle of row 7, so it is high exactly during that cycle.
        frameDoneNext = (stateNext == SCAN) && (rowNext == 3'd7) && (cntNext == CNT_LAST);
    end

    assign {E1, E2, E3, E4, E5} = disp;
    assign {A, B, C}            = row;
    assign frame_done           = frameDoneReg;
    assign code_err             = errReg;
    assign pending              = pendingReg;

endmodule

// File: tb/tb_matrix_row_scanner.sv
module tb_matrix_row_scanner;

    logic clk = 1'b0;
    always #5 clk = ~clk;

    // PRESCALE = 4 instance
    logic       rst, en, load;
    logic [4:0] code;
    logic       e1, e2, e3, e4, e5, a, b, c, fd, err, pend;

    matrix_row_scanner #(.PRESCALE(4)) u4 (
        .clk(clk), .rst(rst), .en(en), .code_in(code), .load(load),
        .E1(e1), .E2(e2), .E3(e3), .E4(e4), .E5(e5),
        .A(a), .B(b), .C(c),
        .frame_done(fd), .code_err(err), .pending(pend)
    );

    // PRESCALE = 1 instance
    logic       rst1, en1, load1;
    logic [4:0] code1;
    logic       f1e1, f1e2, f1e3, f1e4, f1e5, f1a, f1b, f1c, fd1, err1, pend1;

    matrix_row_scanner #(.PRESCALE(1)) u1 (
        .clk(clk), .rst(rst1), .en(en1), .code_in(code1), .load(load1),
        .E1(f1e1), .E2(f1e2), .E3(f1e3), .E4(f1e4), .E5(f1e5),
        .A(f1a), .B(f1b), .C(f1c),
        .frame_done(fd1), .code_err(err1), .pending(pend1)
    );

    int total = 0;
    int bad   = 0;

    typedef struct {
        logic       rst, en, load;
        logic [4:0] code;
        logic [4:0] e;
        logic [2:0] abc;
        logic       fd, err, pend;
    } vecT;

    vecT tbl[10];

    task automatic check(input string name, input int actual, input int expected);
        total++;
        if (actual != expected) begin
            bad++;
            $display("FAIL %s: got %0h want %0h (t=%0t)", name, actual, expected, $time);
        end
    endtask

    task automatic checkAll(input string tag, input logic [4:0] e, input logic [2:0] abc,
                            input logic f, input logic er, input logic p);
        check({tag, ".E"},    int'({e1, e2, e3, e4, e5}), int'(e));
        check({tag, ".ABC"},  int'({a, b, c}), int'(abc));
        check({tag, ".fd"},   int'(fd), int'(f));
        check({tag, ".err"},  int'(err), int'(er));
        check({tag, ".pend"}, int'(pend), int'(p));
    endtask

    task automatic step();
        @(posedge clk);
        #1;
    endtask

    logic [4:0] expE, expShadow;
    logic       expErr, expPend;
    logic [4:0] ldCode;
    logic       ldOn;

    initial begin
        // rst, en, load, code, | E, ABC, fd, err, pend
        tbl[0] = '{1'b1, 1'b0, 1'b0, 5'b00000, 5'b00000, 3'd0, 1'b0, 1'b0, 1'b0};
        tbl[1] = '{1'b1, 1'b1, 1'b0, 5'b00000, 5'b00000, 3'd0, 1'b0, 1'b0, 1'b0};
        tbl[2] = '{1'b0, 1'b1, 1'b0, 5'b00000, 5'b00000, 3'd0, 1'b0, 1'b0, 1'b0};
        tbl[3] = '{1'b0, 1'b1, 1'b1, 5'b10101, 5'b00000, 3'd0, 1'b0, 1'b1, 1'b0};
        tbl[4] = '{1'b0, 1'b1, 1'b1, 5'b11000, 5'b00000, 3'd0, 1'b0, 1'b0, 1'b1};
        tbl[5] = '{1'b0, 1'b1, 1'b0, 5'b00000, 5'b11000, 3'd1, 1'b0, 1'b0, 1'b0};
        tbl[6] = '{1'b0, 1'b1, 1'b0, 5'b00000, 5'b11000, 3'd1, 1'b0, 1'b0, 1'b0};
        tbl[7] = '{1'b0, 1'b1, 1'b0, 5'b00000, 5'b11000, 3'd1, 1'b0, 1'b0, 1'b0};
        tbl[8] = '{1'b0, 1'b1, 1'b0, 5'b00000, 5'b11000, 3'd1, 1'b0, 1'b0, 1'b0};
        tbl[9] = '{1'b0, 1'b1, 1'b0, 5'b00000, 5'b11000, 3'd2, 1'b0, 1'b0, 1'b0};

        rst = 1'b1; en = 1'b0; load = 1'b0; code = '0;
        rst1 = 1'b1; en1 = 1'b0; load1 = 1'b0; code1 = '0;

        // Table: reset, idle hold, invalid then valid load, scan start.
        for (int i = 0; i < 10; i++) begin
            rst = tbl[i].rst; en = tbl[i].en; load = tbl[i].load; code = tbl[i].code;
            step();
            checkAll($sformatf("tbl%0d", i), tbl[i].e, tbl[i].abc, tbl[i].fd, tbl[i].err, tbl[i].pend);
        end

        // Scan frames with mid-scan invalid loads, deferred update,
        // overwrite while pending, and a load on the boundary edge.
        // k counts cycles from the first cycle of row 1 (table step 5 is k=0).
        expE = 5'b11000; expShadow = 5'b11000; expErr = 1'b0; expPend = 1'b0;
        for (int k = 5; k <= 100; k++) begin
            ldOn = 1'b1;
            case (k)
                10: ldCode = 5'b10101;
                11: ldCode = 5'b00000;
                30: ldCode = 5'b00011;
                38: ldCode = 5'b01001;
                84: ldCode = 5'b00110;
                default: begin ldOn = 1'b0; ldCode = 5'b00000; end
            endcase
            load = ldOn; code = ldCode;
            step();
            if (ldOn) begin
                if ($countones(ldCode) == 2) begin
                    expErr = 1'b0; expShadow = ldCode; expPend = 1'b1;
                end else begin
                    expErr = 1'b1;
                end
            end
            if (k % 28 == 0 && expPend) begin
                expE = expShadow; expPend = 1'b0;
            end
            checkAll($sformatf("scan%0d", k), expE, 3'((k / 4) % 7 + 1),
                     (k % 28 == 27), expErr, expPend);
        end
        load = 1'b0; code = '0;

        // k=100 is row 5: drop enable.
        en = 1'b0;
        for (int i = 0; i < 3; i++) begin
            step();
            checkAll($sformatf("endrop%0d", i), 5'b00110, 3'd0, 1'b0, 1'b0, 1'b0);
        end
        en = 1'b1;
        for (int i = 0; i < 5; i++) begin
            step();
            checkAll($sformatf("restart%0d", i), 5'b00110, (i < 4) ? 3'd1 : 3'd2, 1'b0, 1'b0, 1'b0);
        end

        // Reset held for two cycles during scan, then idle with en = 1.
        rst = 1'b1;
        for (int i = 0; i < 2; i++) begin
            step();
            checkAll($sformatf("rst%0d", i), 5'b00000, 3'd0, 1'b0, 1'b0, 1'b0);
        end
        rst = 1'b0;
        for (int i = 0; i < 3; i++) begin
            step();
            checkAll($sformatf("postrst%0d", i), 5'b00000, 3'd0, 1'b0, 1'b0, 1'b0);
        end

        // PRESCALE = 1: row changes every cycle, 7-cycle frames.
        step();
        rst1 = 1'b0; en1 = 1'b1; load1 = 1'b1; code1 = 5'b10001;
        step();
        check("p1.pend", int'(pend1), 1);
        check("p1.ABC0", int'({f1a, f1b, f1c}), 0);
        load1 = 1'b0; code1 = '0;
        for (int k = 0; k < 14; k++) begin
            step();
            check($sformatf("p1.E%0d", k), int'({f1e1, f1e2, f1e3, f1e4, f1e5}), int'(5'b10001));
            check($sformatf("p1.ABC%0d", k), int'({f1a, f1b, f1c}), k % 7 + 1);
            check($sformatf("p1.fd%0d", k), int'(fd1), int'(k % 7 == 6));
        end

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule

// File: doc/matrix_row_scanner.md
# matrix_row_scanner

Row-scan sequencer for the 5×7 LED matrix that displays 2-of-5 coded digits. It accepts a code word on a one-cycle load strobe and validates it as exactly two ones. It holds the word stable for the column decoder on E1..E5 and drives the row-select lines A, B, C through rows 1..7 at a programmable rate. It sits directly upstream of the column-matrix decoder; A/B/C equal to 000 blanks that decoder.

## Interface
- PRESCALE, default 4: clock cycles each row stays selected; legal range 1..1023.
- clk  in  1  system clock; all logic on rising edge.
- rst  in  1  reset, synchronous, active-high.
- en  in  1  scan enable; 0 blanks the display.
- code_in  in  5  candidate code word, bit 4 = E1 … bit 0 = E5.
- load  in  1  one-cycle strobe; code_in sampled on this edge.
- E1..E5  out  1 each  displayed code word, registered, to column decoder.
- A, B, C  out  1 each  row index, A = MSB; 001..111 = rows 1..7, 000 = blank.
- frame_done  out  1  one-cycle pulse on the last cycle of row 7.
- code_err  out  1  sticky invalid-load flag.
- pending  out  1  valid code waiting in the shadow register.

## Operation
- Reset values: E1..E5 = 0, A/B/C = 000, frame_done = 0, code_err = 0, pending = 0. State = IDLE, row = 0, prescale count = 0, shadow = 0.
- Validation: a load is valid iff popcount(code_in) == 2. Any other popcount, including 0 and 5, is invalid.
- Invalid load:
  - sets code_err = 1.
  - shadow, display and scan are unaffected.
- Valid load:
  - clears code_err.
  - writes the shadow register and sets pending = 1.
- States:
  - IDLE: A/B/C = 000. Moves to SCAN when en = 1 and either pending = 1 or E1..E5 ≠ 0. On that transition the shadow is copied to E1..E5 if pending, pending clears, and row = 1.
  - SCAN: the row is held for PRESCALE cycles, then row increments. Row 7 wraps to row 1 at the frame boundary.
- Frame boundary (last cycle of row 7):
  - frame_done = 1.
  - if pending, the shadow is copied to E1..E5 on the same edge that sets row = 1, and pending clears.
  - A new code never appears mid-frame.
- en = 0 in SCAN: next edge goes to IDLE. A/B/C = 000, row and prescale count clear, E1..E5 and shadow retained.
- en = 0 has priority over the frame boundary; frame_done is not asserted in that case.
- Simultaneous valid load and frame boundary: the new code is displayed from row 1 of the next frame, and pending ends at 0.
- Valid load while pending = 1: the shadow is overwritten and only the latest code is shown.
- Prescale counter:
  - width is the ceiling of log2(PRESCALE), minimum 1 bit.
  - counts 0..PRESCALE-1 and wraps with no overflow.
  - PRESCALE = 1 advances the row every cycle.
- rst mid-operation: overrides everything and returns all registers to their reset values on that edge.

## Timing
- All outputs are registered; there are no combinational input-to-output paths.
- load at edge n: code_err and pending update at n+1.
- Valid load from IDLE with en = 1:
  - edge n: code captured; pending = 1.
  - edge n+1: pending is observed, the IDLE→SCAN transition occurs, and pending clears.
  - cycle after edge n+1: A/B/C = 001 and E1..E5 show the new code.
- Frame length is exactly 7 × PRESCALE cycles.
- Rows advance 001 → 010 → … → 111 → 001 with no blank cycle between rows or frames.
- frame_done is high for exactly one cycle per completed frame.

## Test plan
- Reset: assert rst 2 cycles during SCAN -> next cycle all outputs 0 and A/B/C = 000; stays IDLE with en = 1 and no load.
- Valid start: PRESCALE = 4, en = 1, load code_in = 11000 -> E1..E5 = 1,1,0,0,0. Rows 1..7 each held 4 cycles; frame_done pulses every 28 cycles, on the final cycle of row 7.
- Invalid loads: load 10101, then 00000, mid-scan -> code_err = 1, display stays 11000, scan uninterrupted. A following valid load of 00011 clears code_err.
- Deferred update: load 01001 in row 3 -> pending = 1, E1..E5 unchanged through row 7. The new code appears with row 1 of the next frame and pending = 0.
- Boundary collision: load 00110 on the frame_done cycle -> 00110 displayed from row 1 of the immediately following frame.
- Enable/PRESCALE = 1: drop en in row 5 -> A/B/C = 000 next cycle, no frame_done. Re-raise en -> restarts at row 1. Rebuild with PRESCALE = 1: row changes every cycle, 7-cycle frames.
